sam_control_unit: RTL and testbench

//  Multi-cycle FSM that sequences the Very Half SAM datapath: fetch, decode, execute of 8-bit instrs (op[7:4], target[3:0]).

---
 rtl/sam_pkg.sv | 48 ++++
 rtl/sam_decoder.sv | 29 ++
 rtl/sam_control_unit.sv | 163 ++++++++++++++++
 tb/tb_sam_control_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared definitions for the Very Half SAM control unit.
// Opcode values, ALU / accumulator-input select codes, FSM state encoding
// and the decoded-instruction payload passed from the decoder to the FSM.
package sam_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 8;   // holds WAIT_LIMIT up to 255

  localparam logic [OP_W-1:0] OP_LDI = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_STA = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_OR  = 4'h6;
  localparam logic [OP_W-1:0] OP_JMP = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_LDX = 4'h9;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_TGT  = 2'b01;
  localparam logic [1:0] ACC_BUS  = 2'b10;
  localparam logic [1:0] ACC_ALU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM, ST_IND1, ST_IND2, ST_HALT, ST_ERROR
  } state_t;

  typedef struct packed {
    logic       is_mem;   // single direct memory access (LDA/STA/ALU ops)
    logic       is_wr;    // that access is a write (STA)
    logic       is_ind;   // two-step indirect load (LDX)
    logic       is_jmp;
    logic       is_jz;
    logic       is_ldi;
    logic       is_hlt;
    logic [1:0] alu_sel;
    logic [1:0] acc_sel;
  } dec_t;

endpackage

// File: rtl/sam_decoder.sv
// Combinational opcode decoder.
//  op     in  4  instruction opcode (IReg[7:4])
//  dec_c  out    decoded instruction class and datapath select codes
module sam_decoder
  import sam_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec_c
);

  always_comb begin
    dec_c = '0;
    case (op)
      OP_LDI: begin dec_c.is_ldi = 1'b1; dec_c.acc_sel = ACC_TGT; end
      OP_LDA: begin dec_c.is_mem = 1'b1; dec_c.acc_sel = ACC_BUS; end
      OP_STA: begin dec_c.is_mem = 1'b1; dec_c.is_wr = 1'b1; end
      OP_ADD: begin dec_c.is_mem = 1'b1; dec_c.alu_sel = ALU_ADD; dec_c.acc_sel = ACC_ALU; end
      OP_SUB: begin dec_c.is_mem = 1'b1; dec_c.alu_sel = ALU_SUB; dec_c.acc_sel = ACC_ALU; end
      OP_AND: begin dec_c.is_mem = 1'b1; dec_c.alu_sel = ALU_AND; dec_c.acc_sel = ACC_ALU; end
      OP_OR:  begin dec_c.is_mem = 1'b1; dec_c.alu_sel = ALU_OR;  dec_c.acc_sel = ACC_ALU; end
      OP_JMP: dec_c.is_jmp = 1'b1;
      OP_JZ:  dec_c.is_jz  = 1'b1;
      OP_LDX: begin dec_c.is_ind = 1'b1; dec_c.acc_sel = ACC_BUS; end
      OP_HLT: dec_c.is_hlt = 1'b1;
      default: ;  // A-E are NOPs
    endcase
  end

endmodule

// File: rtl/sam_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the Very Half SAM datapath.
// Every memory access waits on Mem_Ready; an access that waits WAIT_LIMIT
// cycles without completing parks the unit in ERROR until reset.
//  clk, rst                       clock, async active-low reset
//  IReg_Data_Out, Acc_Data_Out    instruction and accumulator from datapath
//  Mem_Ready                      memory completes current access this cycle
//  *_En, *_Sel, Mem_Rd, Mem_Wr    datapath controls and memory strobes
//  Halted, Fault                  sticky status (HALT / ERROR state)
// Controls are decoded from the current state (and Mem_Ready for enables),
// so they drop to zero in the same cycle reset is asserted.
module sam_control_unit
  import sam_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] IReg_Data_Out,
  input  logic [WORD_W-1:0] Acc_Data_Out,
  input  logic              Mem_Ready,
  output logic              IReg_En,
  output logic              PC_En,
  output logic              IAR_En,
  output logic              Acc_En,
  output logic              Mux_PC_Add_Sel,
  output logic              Mux_PC_In_Sel,
  output logic              IReg_Buffer_Sel,
  output logic              PC_Buffer_Sel,
  output logic              IAR_Buffer_Sel,
  output logic              Acc_Buffer_Sel,
  output logic [1:0]        Mux_Acc_In_Sel,
  output logic [1:0]        ALU_Sel,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic              Halted,
  output logic              Fault
);

  state_t            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  dec_t              dec_c;
  logic              mem_state_c;
  logic              timeout_c;
  logic              unused_target;

  // Target field is routed by the datapath, not by this block.
  assign unused_target = ^IReg_Data_Out[OP_W-1:0];

  sam_decoder u_dec (
    .op    (IReg_Data_Out[WORD_W-1:OP_W]),
    .dec_c (dec_c)
  );

  assign mem_state_c = (state == ST_FETCH) || (state == ST_MEM) ||
                       (state == ST_IND1)  || (state == ST_IND2);
  // Last permitted wait cycle with memory still busy.
  assign timeout_c   = mem_state_c && !Mem_Ready &&
                       (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Wait counter: restarts on every state change, counts stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           wait_cnt <= '0;
    else if (next_state != state)       wait_cnt <= '0;
    else if (mem_state_c && !Mem_Ready) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state and control decode
  always_comb begin
    next_state      = state;
    IReg_En         = 1'b0;
    PC_En           = 1'b0;
    IAR_En          = 1'b0;
    Acc_En          = 1'b0;
    Mux_PC_Add_Sel  = 1'b0;
    Mux_PC_In_Sel   = 1'b0;
    IReg_Buffer_Sel = 1'b0;
    PC_Buffer_Sel   = 1'b0;
    IAR_Buffer_Sel  = 1'b0;
    Acc_Buffer_Sel  = 1'b0;
    Mux_Acc_In_Sel  = ACC_NONE;
    ALU_Sel         = ALU_ADD;
    Mem_Rd          = 1'b0;
    Mem_Wr          = 1'b0;
    Halted          = 1'b0;
    Fault           = 1'b0;

    case (state)
      ST_IDLE: next_state = ST_FETCH;

      ST_FETCH: begin
        PC_Buffer_Sel  = 1'b1;
        Mem_Rd         = 1'b1;
        Mux_PC_In_Sel  = 1'b1;
        Mux_PC_Add_Sel = 1'b1;
        if (Mem_Ready) begin
          IReg_En    = 1'b1;
          PC_En      = 1'b1;
          next_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        next_state = ST_FETCH;
        if (dec_c.is_ldi) begin
          Acc_En         = 1'b1;
          Mux_Acc_In_Sel = dec_c.acc_sel;
        end else if (dec_c.is_jmp || (dec_c.is_jz && (Acc_Data_Out == '0))) begin
          // PC already points past this instruction; offset adds to that.
          PC_En         = 1'b1;
          Mux_PC_In_Sel = 1'b1;
        end else if (dec_c.is_hlt) begin
          next_state = ST_HALT;
        end else if (dec_c.is_mem) begin
          next_state = ST_MEM;
        end else if (dec_c.is_ind) begin
          next_state = ST_IND1;
        end
      end

      ST_MEM: begin
        IReg_Buffer_Sel = 1'b1;
        if (dec_c.is_wr) begin
          Mem_Wr         = 1'b1;
          Acc_Buffer_Sel = 1'b1;
        end else begin
          Mem_Rd         = 1'b1;
          ALU_Sel        = dec_c.alu_sel;
          Mux_Acc_In_Sel = dec_c.acc_sel;
          Acc_En         = Mem_Ready;
        end
        if (Mem_Ready) next_state = ST_FETCH;
      end

      ST_IND1: begin
        IReg_Buffer_Sel = 1'b1;
        Mem_Rd          = 1'b1;
        IAR_En          = Mem_Ready;
        if (Mem_Ready) next_state = ST_IND2;
      end

      ST_IND2: begin
        IAR_Buffer_Sel = 1'b1;
        Mem_Rd         = 1'b1;
        Mux_Acc_In_Sel = ACC_BUS;
        Acc_En         = Mem_Ready;
        if (Mem_Ready) next_state = ST_FETCH;
      end

      ST_HALT:  Halted = 1'b1;
      ST_ERROR: Fault  = 1'b1;
      default:  next_state = ST_ERROR;
    endcase

    if (timeout_c) next_state = ST_ERROR;
  end

endmodule

// File: tb/tb_sam_control_unit.sv
// Directed bench for sam_control_unit: runs a short program out of a small
// datapath/memory model and checks the control vector cycle by cycle.
module tb_sam_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Mem_Ready = 1'b1;
  logic       IReg_En, PC_En, IAR_En, Acc_En, Mux_PC_Add_Sel, Mux_PC_In_Sel;
  logic       IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel;
  logic [1:0] Mux_Acc_In_Sel, ALU_Sel;
  logic       Mem_Rd, Mem_Wr, Halted, Fault;

  logic [7:0] pc, ireg, iar, acc, addr, rdata, alu, pc_init;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [17:0] outs;
  int total = 0;
  int bad = 0;
  int inv_bad = 0;

  always #5 clk = ~clk;

  sam_control_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .IReg_Data_Out(ireg), .Acc_Data_Out(acc),
    .Mem_Ready(Mem_Ready), .IReg_En(IReg_En), .PC_En(PC_En), .IAR_En(IAR_En),
    .Acc_En(Acc_En), .Mux_PC_Add_Sel(Mux_PC_Add_Sel), .Mux_PC_In_Sel(Mux_PC_In_Sel),
    .IReg_Buffer_Sel(IReg_Buffer_Sel), .PC_Buffer_Sel(PC_Buffer_Sel),
    .IAR_Buffer_Sel(IAR_Buffer_Sel), .Acc_Buffer_Sel(Acc_Buffer_Sel),
    .Mux_Acc_In_Sel(Mux_Acc_In_Sel), .ALU_Sel(ALU_Sel), .Mem_Rd(Mem_Rd),
    .Mem_Wr(Mem_Wr), .Halted(Halted), .Fault(Fault)
  );

  assign outs = {IReg_En, PC_En, IAR_En, Acc_En, Mux_PC_Add_Sel, Mux_PC_In_Sel,
                 IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel,
                 Mux_Acc_In_Sel, ALU_Sel, Mem_Rd, Mem_Wr, Halted, Fault};

  localparam logic [17:0] IREN   = 18'(1) << 17;
  localparam logic [17:0] PCEN   = 18'(1) << 16;
  localparam logic [17:0] IAREN  = 18'(1) << 15;
  localparam logic [17:0] ACCEN  = 18'(1) << 14;
  localparam logic [17:0] ADD1   = 18'(1) << 13;
  localparam logic [17:0] INADD  = 18'(1) << 12;
  localparam logic [17:0] IRBUF  = 18'(1) << 11;
  localparam logic [17:0] PCBUF  = 18'(1) << 10;
  localparam logic [17:0] IARBUF = 18'(1) << 9;
  localparam logic [17:0] ACCBUF = 18'(1) << 8;
  localparam logic [17:0] SEL_T  = 18'(1) << 6;
  localparam logic [17:0] SEL_D  = 18'(2) << 6;
  localparam logic [17:0] SEL_A  = 18'(3) << 6;
  localparam logic [17:0] RD     = 18'(1) << 3;
  localparam logic [17:0] WR     = 18'(1) << 2;
  localparam logic [17:0] HLT    = 18'(1) << 1;
  localparam logic [17:0] FLT    = 18'(1);

  localparam logic [17:0] V_FETCH = IREN | PCEN | ADD1 | INADD | PCBUF | RD;
  localparam logic [17:0] V_LDI   = ACCEN | SEL_T;
  localparam logic [17:0] V_JUMP  = PCEN | INADD;
  localparam logic [17:0] V_STA   = IRBUF | WR | ACCBUF;
  localparam logic [17:0] V_ADD   = IRBUF | RD | SEL_A | ACCEN;
  localparam logic [17:0] V_IND1  = IRBUF | RD | IAREN;
  localparam logic [17:0] V_IND2  = IARBUF | RD | SEL_D | ACCEN;
  localparam logic [17:0] M_FWAIT = IREN | PCEN | PCBUF | RD | FLT;

  // Datapath / memory model driven by the DUT controls
  always_comb begin
    addr = 8'h00;
    if (PC_Buffer_Sel)        addr = pc;
    else if (IReg_Buffer_Sel) addr = {4'h0, ireg[3:0]};
    else if (IAR_Buffer_Sel)  addr = iar;
  end
  assign rdata = mem[addr];

  always_comb begin
    case (ALU_Sel)
      2'b00:   alu = acc + rdata;
      2'b01:   alu = acc - rdata;
      2'b10:   alu = acc & rdata;
      default: alu = acc | rdata;
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= pc_init; acc <= 8'h00; ireg <= 8'h00; iar <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else begin
      if (IReg_En) ireg <= rdata;
      if (IAR_En)  iar  <= rdata;
      if (PC_En)
        pc <= Mux_PC_In_Sel ? (pc + (Mux_PC_Add_Sel ? 8'd1 : {4'h0, ireg[3:0]})) : rdata;
      if (Acc_En) begin
        case (Mux_Acc_In_Sel)
          2'b01:   acc <= {4'h0, ireg[3:0]};
          2'b10:   acc <= rdata;
          2'b11:   acc <= alu;
          default: acc <= acc;
        endcase
      end
      if (Mem_Wr && Mem_Ready) mem[addr] <= acc;
    end
  end

  // Structural invariants watched on every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      if (($countones({IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel}) > 1) ||
          (Acc_Buffer_Sel && !Mem_Wr) || (Acc_Buffer_Sel && Acc_En) || (Mem_Rd && Mem_Wr))
        inv_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch followed by the decode cycle of the fetched instruction
  task automatic fetch_dec(input string tag, input logic [17:0] dec_exp);
    chk({tag, "_fetch"}, 32'(outs), 32'(V_FETCH));
    tick();
    chk({tag, "_dec"}, 32'(outs), 32'(dec_exp));
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h04] = 8'h20;  img[8'h20] = 8'h77;
    img[8'h10] = 8'h05;  // LDI 5
    img[8'h11] = 8'h73;  // JMP +3 -> 0x15
    img[8'h15] = 8'h82;  // JZ (ACC=5, not taken)
    img[8'h16] = 8'h00;  // LDI 0
    img[8'h17] = 8'h82;  // JZ (taken) -> 0x1A
    img[8'h1A] = 8'h09;  // LDI 9
    img[8'h1B] = 8'h2A;  // STA 0xA
    img[8'h1C] = 8'h3A;  // ADD 0xA
    img[8'h1D] = 8'h94;  // LDX 4
    img[8'h1E] = 8'hA0;  // NOP
    img[8'h1F] = 8'hF0;  // HLT
    pc_init = 8'h10;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(outs), 32'h0);
    rst = 1'b1;
    chk("idle", 32'(outs), 32'h0);
    tick();

    fetch_dec("ldi5", V_LDI);
    fetch_dec("jmp", V_JUMP);
    chk("pc_jmp", 32'(pc), 32'h15);
    chk("acc_ldi", 32'(acc), 32'h05);
    fetch_dec("jz_nt", 18'h0);
    chk("pc_jz_nt", 32'(pc), 32'h16);
    fetch_dec("ldi0", V_LDI);
    fetch_dec("jz_t", V_JUMP);
    chk("pc_jz_t", 32'(pc), 32'h1A);
    fetch_dec("ldi9", V_LDI);

    // STA with three stalled cycles, completing on the last allowed one
    fetch_dec("sta", 18'h0);
    Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sta_wait", 32'(outs), 32'(V_STA));
      tick();
    end
    Mem_Ready = 1'b1;
    chk("sta_done", 32'(outs), 32'(V_STA));
    tick();
    chk("sta_mem", 32'(mem[8'h0A]), 32'h09);

    fetch_dec("add", 18'h0);
    chk("add_mem", 32'(outs), 32'(V_ADD));
    tick();
    chk("acc_add", 32'(acc), 32'h12);

    fetch_dec("ldx", 18'h0);
    chk("ind1", 32'(outs), 32'(V_IND1));
    tick();
    chk("ind2", 32'(outs), 32'(V_IND2));
    tick();
    chk("acc_ldx", 32'(acc), 32'h77);
    chk("iar_ldx", 32'(iar), 32'h20);

    fetch_dec("nop", 18'h0);
    fetch_dec("hlt", 18'h0);
    chk("halt", 32'(outs), 32'(HLT));
    tick();
    chk("halt_sticky", 32'(outs), 32'(HLT));

    // Reset out of HALT, then reset again in the middle of a stalled STA
    pc_init = 8'h1B;
    rst = 1'b0;
    #1;
    chk("rst_halt", 32'(outs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_idle0", 32'(outs), 32'h0);
    tick();
    fetch_dec("sta2", 18'h0);
    Mem_Ready = 1'b0;
    chk("rst_mem0", 32'(outs), 32'(V_STA));
    tick();
    chk("rst_mem1", 32'(outs), 32'(V_STA));
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(outs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_idle1", 32'(outs), 32'h0);
    tick();

    // Fetch never acknowledged: four stalled cycles, then Fault
    for (int i = 0; i < 4; i++) begin
      chk("fetch_stall", 32'(outs & M_FWAIT), 32'(PCBUF | RD));
      tick();
    end
    chk("fault", 32'(outs), 32'(FLT));
    Mem_Ready = 1'b1;
    tick();
    chk("fault_sticky", 32'(outs), 32'(FLT));
    tick();
    chk("fault_sticky2", 32'(outs), 32'(FLT));

    chk("invariants", 32'(inv_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
